// File: rtl/progmem_loader.sv
// Byte-stream program loader: assembles {opcode, operand} words and writes them to program memory.
// Optional checksum byte at end of image when PROGMEM_LOADER_CHECKSUM_EN is defined.
//
// state   | meaning
// IDLE    | waiting for start
// COUNT   | accept word count N (0 means DEPTH)
// HI      | accept opcode byte, upper five bits must be zero
// LO      | accept operand byte, write word on next cycle
// CSUM    | accept checksum byte (checksum build only)
// DONE    | image loaded, core released
// ERR     | load failed, core held
module progmem_loader #(
    parameter int PROG_WIDTH = 11,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  pm_we,
    output logic [ADDR_WIDTH-1:0] pm_addr,
    output logic [PROG_WIDTH-1:0] pm_wdata,
    output logic                  cpu_run,
    output logic                  load_done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_HI    = 3'd2,
        S_LO    = 3'd3,
`ifdef PROGMEM_LOADER_CHECKSUM_EN
        S_CSUM  = 3'd4,
`endif
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] index;
    logic [ADDR_WIDTH:0]   count;
    logic [2:0]            hi_op;
    logic                  accept;
    logic                  last;

    assign accept = in_valid && in_ready;
    assign last   = ({1'b0, index} == (count - (ADDR_WIDTH+1)'(1)));

`ifdef PROGMEM_LOADER_CHECKSUM_EN
    logic [7:0] sum;
    logic [7:0] sum_next;
    assign sum_next = sum + in_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            pm_we     <= 1'b0;
            pm_addr   <= '0;
            pm_wdata  <= '0;
            cpu_run   <= 1'b0;
            load_done <= 1'b0;
            error     <= 1'b0;
            index     <= '0;
            count     <= '0;
            hi_op     <= '0;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            pm_we     <= 1'b0;
            load_done <= 1'b0;
            // start wins over everything, including a byte offered on the same edge
            if (start) begin
                state    <= S_COUNT;
                in_ready <= 1'b1;
                cpu_run  <= 1'b0;
                error    <= 1'b0;
                index    <= '0;
            end else begin
                unique case (state)
                    S_COUNT: if (accept) begin
                        count <= (in_data == 8'h00) ? (ADDR_WIDTH+1)'(DEPTH)
                                                    : (ADDR_WIDTH+1)'(in_data);
                        index <= '0;
                        state <= S_HI;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
                        sum   <= in_data;
`endif
                    end
                    S_HI: if (accept) begin
                        if (in_data[7:3] != 5'd0) begin
                            state    <= S_ERR;
                            in_ready <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            hi_op <= in_data[2:0];
                            state <= S_LO;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
                            sum   <= sum_next;
`endif
                        end
                    end
                    S_LO: if (accept) begin
                        pm_we    <= 1'b1;
                        pm_addr  <= index;
                        pm_wdata <= PROG_WIDTH'({hi_op, in_data});
                        index    <= index + 1'b1;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
                        sum      <= sum_next;
`endif
                        if (last) begin
`ifdef PROGMEM_LOADER_CHECKSUM_EN
                            state <= S_CSUM;
`else
                            state    <= S_DONE;
                            in_ready <= 1'b0;
`endif
                        end else begin
                            state <= S_HI;
                        end
                    end
`ifdef PROGMEM_LOADER_CHECKSUM_EN
                    S_CSUM: if (accept) begin
                        in_ready <= 1'b0;
                        if (sum_next == 8'h00) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end
`endif
                    // load_done fires on the first cycle cpu_run goes high
                    S_DONE: begin
                        cpu_run   <= 1'b1;
                        load_done <= !cpu_run;
                    end
                    S_ERR: begin
                        cpu_run <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_progmem_loader.sv
// Scoreboard bench for progmem_loader: driver pushes expected writes, monitor pops on pm_we.
module tb_progmem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, pm_we, cpu_run, load_done, error;
    logic [7:0]  pm_addr;
    logic [10:0] pm_wdata;

    progmem_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
        .cpu_run(cpu_run), .load_done(load_done), .error(error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc = 0;
    int last_we_cyc = -10;
    int done_cnt = 0;
    int gap = 0;
    logic [18:0] exp_q[$];
    logic [7:0]  img[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: compare every write against the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && pm_we) begin
            last_we_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {pm_addr, pm_wdata}, 32'hFFFFFFFF);
            end else begin
                logic [18:0] e;
                e = exp_q.pop_front();
                chk("write_addr", pm_addr, e[18:11]);
                chk("write_data", pm_wdata, e[10:0]);
            end
        end
        if (rst_n && load_done) begin
            done_cnt++;
`ifndef PROGMEM_LOADER_CHECKSUM_EN
            chk("done_latency", cyc, last_we_cyc + 1);
`endif
        end
    end

    task automatic push_exp(input logic [7:0] a, input logic [10:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        for (int i = 0; i < gap; i++) @(posedge clk);
        #1;
    endtask

    task automatic send_image();
        logic [7:0] s;
        s = 8'h00;
        foreach (img[i]) begin
            send(img[i]);
            s = s + img[i];
        end
`ifdef PROGMEM_LOADER_CHECKSUM_EN
        send(8'h00 - s);
`endif
    endtask

    task automatic pulse_start(input logic with_byte);
        @(negedge clk);
        start    = 1'b1;
        in_valid = with_byte;
        in_data  = 8'hAA;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic wait_flag(input logic want_err);
        int n = 0;
        while (!(want_err ? error : cpu_run) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk(want_err ? "wait_error" : "wait_run", want_err ? error : cpu_run, 1);
    endtask

    task automatic expect_done(input int d0);
        wait_flag(1'b0);
        chk("cpu_run", cpu_run, 1);
        chk("error_clear", error, 0);
        chk("load_done_once", done_cnt - d0, 1);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    task automatic load_basic();
        img = '{8'h06, 8'h02, 8'h0A, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05,
                8'h03, 8'h00, 8'h04, 8'h05};
        push_exp(8'd0, 11'h20A); push_exp(8'd1, 11'h300); push_exp(8'd2, 11'h000);
        push_exp(8'd3, 11'h005); push_exp(8'd4, 11'h300); push_exp(8'd5, 11'h405);
    endtask

    initial begin
        int d0;
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_outputs", {pm_we, pm_addr, pm_wdata, cpu_run, load_done, error}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic image
        d0 = done_cnt;
        pulse_start(1'b0);
        load_basic();
        send_image();
        expect_done(d0);

        // idle with valid held: nothing accepted, then gapped stream
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h06;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        gap = 1;
        d0 = done_cnt;
        pulse_start(1'b0);
        load_basic();
        send_image();
        expect_done(d0);
        gap = 0;

        // bad HI byte
        pulse_start(1'b0);
        chk("start_clears_run", cpu_run, 0);
        send(8'h01);
        send(8'h12);
        wait_flag(1'b1);
        chk("err_cpu_run", cpu_run, 0);
        chk("err_in_ready", in_ready, 0);
        d0 = done_cnt;
        pulse_start(1'b0);
        chk("start_clears_err", error, 0);
        load_basic();
        send_image();
        expect_done(d0);

        // full 256-word image
        d0 = done_cnt;
        pulse_start(1'b0);
        img = '{8'h00};
        for (int i = 0; i < 256; i++) begin
            img.push_back(8'h07);
            img.push_back(8'(i));
            push_exp(8'(i), 11'h700 | 11'(i));
        end
        send_image();
        expect_done(d0);

        // abort mid-pair with a byte offered on the start edge
        pulse_start(1'b0);
        push_exp(8'd0, 11'h201);
        send(8'h03); send(8'h02); send(8'h01); send(8'h01);
        d0 = done_cnt;
        pulse_start(1'b1);
        push_exp(8'd0, 11'h0FF);
        img = '{8'h01, 8'h00, 8'hFF};
        send_image();
        expect_done(d0);

        // reset mid-load
        pulse_start(1'b0);
        push_exp(8'd0, 11'h201);
        send(8'h03); send(8'h02); send(8'h01); send(8'h01);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {in_ready, pm_we, pm_addr, pm_wdata, cpu_run, load_done, error}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_queue", exp_q.size(), 0);

`ifdef PROGMEM_LOADER_CHECKSUM_EN
        d0 = done_cnt;
        pulse_start(1'b0);
        push_exp(8'd0, 11'h20A);
        send(8'h01); send(8'h02); send(8'h0A); send(8'hF3);
        expect_done(d0);
        pulse_start(1'b0);
        push_exp(8'd0, 11'h20A);
        send(8'h01); send(8'h02); send(8'h0A); send(8'hF4);
        wait_flag(1'b1);
        chk("csum_err_run", cpu_run, 0);
        chk("csum_queue", exp_q.size(), 0);
`endif

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
